// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds the branch-condition and next-PC-source encodings used by the
// decode logic and the sequencer, plus the default PC / jump-target widths.
package pc_sequencer_pkg;

  localparam int PC_W_DEFAULT  = 30;
  localparam int JTA_W_DEFAULT = 26;

  // Branch condition select. Signed compares use sign^overflow, unsigned
  // compares use carry as a borrow indicator.
  typedef enum logic [2:0] {
    BR_ALWAYS = 3'd0,
    BR_Z      = 3'd1,
    BR_NZ     = 3'd2,
    BR_LT     = 3'd3,
    BR_GE     = 3'd4,
    BR_LTU    = 3'd5,
    BR_GEU    = 3'd6,
    BR_NEVER  = 3'd7
  } brType_e;

  // Next-PC source select.
  typedef enum logic [1:0] {
    PCSEL_INCR   = 2'b00,
    PCSEL_BRANCH = 2'b01,
    PCSEL_REG    = 2'b10,
    PCSEL_RET    = 2'b11
  } pcSel_e;

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// branch_cond_eval: purely combinational decoder from ALU flags and a
// branch-condition select to a single "branch taken" bit.
// Ports:
//   zFlag, carryFlag, signFlag, overflowFlag : ALU condition flags
//   brType                                   : condition select (brType_e)
//   brTrue                                   : 1 when the condition holds
module branch_cond_eval
  import pc_sequencer_pkg::*;
(
  input  logic       zFlag,
  input  logic       carryFlag,
  input  logic       signFlag,
  input  logic       overflowFlag,
  input  logic [2:0] brType,
  output logic       brTrue
);

  logic signedLess;

  // Signed less-than after a subtract is sign xor overflow.
  assign signedLess = signFlag ^ overflowFlag;

  // Condition table; every encoding is defined so no default path is live.
  always_comb begin
    brTrue = 1'b0;
    case (brType_e'(brType))
      BR_ALWAYS: brTrue = 1'b1;
      BR_Z:      brTrue = zFlag;
      BR_NZ:     brTrue = ~zFlag;
      BR_LT:     brTrue = signedLess;
      BR_GE:     brTrue = ~signedLess;
      BR_LTU:    brTrue = carryFlag;
      BR_GEU:    brTrue = ~carryFlag;
      BR_NEVER:  brTrue = 1'b0;
      default:   brTrue = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with stall handshake and a
// circular hardware return-address stack (RAS).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   advance         : 1 = PC/RAS update this cycle, 0 = stall
//   zFlag..overflowFlag, brType : branch condition inputs
//   pcSel           : next-PC source (pcSel_e)
//   isCall          : push pc+1 as return address when advancing
//   register, jta   : register-indirect target, jump-target field
//   pc              : architectural PC (registered)
//   incr_pc, next_pc: pc+1 and the PC taken on an advancing edge
//   ras_empty/full  : RAS occupancy flags
//   ras_underflow   : one-cycle pulse after a return with an empty RAS
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEFAULT,
  parameter int              JTA_W     = JTA_W_DEFAULT,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              zFlag,
  input  logic              carryFlag,
  input  logic              signFlag,
  input  logic              overflowFlag,
  input  logic [2:0]        brType,
  input  logic [1:0]        pcSel,
  input  logic              isCall,
  input  logic [PC_W-1:0]   register,
  input  logic [JTA_W-1:0]  jta,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   incr_pc,
  output logic [PC_W-1:0]   next_pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              brTrue;
  logic [PC_W-1:0]   branchTarget;
  logic [PC_W-1:0]   rasMem [RAS_DEPTH];
  logic [PTR_W-1:0]  rasPtr;
  logic [PTR_W-1:0]  topIdx;
  logic [CNT_W-1:0]  rasCount;
  logic [PC_W-1:0]   rasTop;
  logic              isRet;

  logic [PTR_W-1:0]  ptrNext;
  logic [CNT_W-1:0]  countNext;
  logic              memWe;
  logic [PTR_W-1:0]  memAddr;
  logic              underflowNext;

  branch_cond_eval uBranchCond (
    .zFlag        (zFlag),
    .carryFlag    (carryFlag),
    .signFlag     (signFlag),
    .overflowFlag (overflowFlag),
    .brType       (brType),
    .brTrue       (brTrue)
  );

  // The pointer addresses the next free slot, so the top entry sits one
  // below it; power-of-two depth makes the subtraction wrap for free.
  assign topIdx       = rasPtr - PTR_W'(1);
  assign rasTop       = rasMem[topIdx];
  assign ras_empty    = (rasCount == '0);
  assign ras_full     = (rasCount == CNT_W'(RAS_DEPTH));
  assign isRet        = (pcSel_e'(pcSel) == PCSEL_RET);

  assign incr_pc      = pc + PC_W'(1);
  assign branchTarget = {pc[PC_W-1:JTA_W], jta};

  // Next-PC mux. A return with an empty stack falls back to the register
  // so software can keep its own return address.
  always_comb begin
    next_pc = incr_pc;
    case (pcSel_e'(pcSel))
      PCSEL_INCR:   next_pc = incr_pc;
      PCSEL_BRANCH: next_pc = brTrue ? branchTarget : incr_pc;
      PCSEL_REG:    next_pc = register;
      PCSEL_RET:    next_pc = ras_empty ? register : rasTop;
      default:      next_pc = incr_pc;
    endcase
  end

  // RAS control. A return combined with a call (tail call through the
  // return path) overwrites the popped top in place, leaving pointer and
  // count alone; if the stack is empty it degrades to a plain push while
  // still flagging the underflow. Plain pushes wrap over the oldest entry
  // once full, so the count saturates rather than the pointer stopping.
  always_comb begin
    ptrNext       = rasPtr;
    countNext     = rasCount;
    memWe         = 1'b0;
    memAddr       = rasPtr;
    underflowNext = 1'b0;
    if (advance) begin
      if (isRet) begin
        if (ras_empty) begin
          underflowNext = 1'b1;
          if (isCall) begin
            memWe     = 1'b1;
            memAddr   = rasPtr;
            ptrNext   = rasPtr + PTR_W'(1);
            countNext = rasCount + CNT_W'(1);
          end
        end else if (isCall) begin
          memWe   = 1'b1;
          memAddr = topIdx;
        end else begin
          ptrNext   = topIdx;
          countNext = rasCount - CNT_W'(1);
        end
      end else if (isCall) begin
        memWe   = 1'b1;
        memAddr = rasPtr;
        ptrNext = rasPtr + PTR_W'(1);
        if (!ras_full) begin
          countNext = rasCount + CNT_W'(1);
        end
      end
    end
  end

  // Architectural state. A stall holds everything but still clears the
  // underflow pulse so it never lasts longer than one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      rasPtr        <= '0;
      rasCount      <= '0;
      ras_underflow <= 1'b0;
    end else begin
      if (advance) begin
        pc <= next_pc;
      end
      rasPtr        <= ptrNext;
      rasCount      <= countNext;
      ras_underflow <= underflowNext;
    end
  end

  // Stack storage needs no reset: entries are only read when the count
  // says they are valid.
  always_ff @(posedge clk) begin
    if (memWe) begin
      rasMem[memAddr] <= incr_pc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (PC_W=30, JTA_W=24, RAS_DEPTH=4,
// RESET_PC=0x100). Each task drives one scenario and checks inline.
module tb_pc_sequencer;

  localparam int PC_W  = 30;
  localparam int JTA_W = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              advance;
  logic              zFlag, carryFlag, signFlag, overflowFlag;
  logic [2:0]        brType;
  logic [1:0]        pcSel;
  logic              isCall;
  logic [PC_W-1:0]   register;
  logic [JTA_W-1:0]  jta;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   incr_pc;
  logic [PC_W-1:0]   next_pc;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_underflow;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(
    .PC_W      (PC_W),
    .JTA_W     (JTA_W),
    .RAS_DEPTH (4),
    .RESET_PC  (30'h100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance       (advance),
    .zFlag         (zFlag),
    .carryFlag     (carryFlag),
    .signFlag      (signFlag),
    .overflowFlag  (overflowFlag),
    .brType        (brType),
    .pcSel         (pcSel),
    .isCall        (isCall),
    .register      (register),
    .jta           (jta),
    .pc            (pc),
    .incr_pc       (incr_pc),
    .next_pc       (next_pc),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  // Advance time past the next rising edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One advancing cycle with the given source/target/call bit.
  task automatic go(input logic [1:0] sel, input logic [PC_W-1:0] reg_v, input logic call);
    advance  = 1'b1;
    pcSel    = sel;
    register = reg_v;
    isCall   = call;
    tick();
    isCall   = 1'b0;
    pcSel    = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; advance = 1'b0; zFlag = 0; carryFlag = 0; signFlag = 0; overflowFlag = 0;
    brType = 3'd0; pcSel = 2'b00; isCall = 1'b0; register = '0; jta = '0;
    tick(); tick();
    checks++; if (pc !== 30'h100) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 30'h100); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", ras_full); end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_underflow: got %b expected 0", ras_underflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_increment();
    logic [PC_W-1:0] exp;
    advance = 1'b1; pcSel = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = 30'h100 + PC_W'(i);
      checks++; if (pc !== exp) begin errors++; $display("[TB] FAIL incr_%0d: got %h expected %h", i, pc, exp); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL incr_empty: got %b expected 1", ras_empty); end
  endtask

  task automatic test_branch();
    go(2'b10, 30'h3000005, 1'b0);
    jta = 24'h000040; brType = 3'd1; zFlag = 1'b1;
    go(2'b01, '0, 1'b0);
    checks++; if (pc !== 30'h3000040) begin errors++; $display("[TB] FAIL br_z_taken: got %h expected %h", pc, 30'h3000040); end
    go(2'b10, 30'h3000005, 1'b0);
    zFlag = 1'b0;
    go(2'b01, '0, 1'b0);
    checks++; if (pc !== 30'h3000006) begin errors++; $display("[TB] FAIL br_z_not_taken: got %h expected %h", pc, 30'h3000006); end
  endtask

  // Full condition table checked on next_pc while stalled at 0x3000005.
  task automatic test_branch_sweep();
    logic [7:0]      takenVec;
    logic [PC_W-1:0] exp;
    logic            z, c, s, v;
    go(2'b10, 30'h3000005, 1'b0);
    advance = 1'b0; pcSel = 2'b01; jta = 24'h000040;
    for (int f = 0; f < 16; f++) begin
      z = f[0]; c = f[1]; s = f[2]; v = f[3];
      zFlag = z; carryFlag = c; signFlag = s; overflowFlag = v;
      // bit k = taken for brType k
      takenVec = {1'b0, ~c, c, ~(s ^ v), s ^ v, ~z, z, 1'b1};
      for (int b = 0; b < 8; b++) begin
        brType = 3'(b);
        #1;
        exp = takenVec[b] ? 30'h3000040 : 30'h3000006;
        checks++; if (next_pc !== exp) begin errors++; $display("[TB] FAIL sweep_br%0d_f%0d: got %h expected %h", b, f, next_pc, exp); end
      end
    end
    checks++; if (pc !== 30'h3000005) begin errors++; $display("[TB] FAIL sweep_hold: got %h expected %h", pc, 30'h3000005); end
    zFlag = 0; carryFlag = 0; signFlag = 0; overflowFlag = 0; brType = 3'd0;
  endtask

  task automatic test_stall();
    go(2'b10, 30'h20, 1'b0);
    advance = 1'b0; pcSel = 2'b10; register = 30'h55; isCall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pc !== 30'h20) begin errors++; $display("[TB] FAIL stall_pc_%0d: got %h expected %h", i, pc, 30'h20); end
      checks++; if (next_pc !== 30'h55) begin errors++; $display("[TB] FAIL stall_next_%0d: got %h expected %h", i, next_pc, 30'h55); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL stall_no_push: got %b expected 1", ras_empty); end
    go(2'b10, 30'h55, 1'b0);
    checks++; if (pc !== 30'h55) begin errors++; $display("[TB] FAIL stall_release: got %h expected %h", pc, 30'h55); end
  endtask

  task automatic test_call_return();
    go(2'b10, 30'h10, 1'b0);
    go(2'b10, 30'h80, 1'b1);
    go(2'b10, 30'h90, 1'b1);
    checks++; if (pc !== 30'h90) begin errors++; $display("[TB] FAIL call_pc: got %h expected %h", pc, 30'h90); end
    go(2'b11, 30'h999, 1'b0);
    checks++; if (pc !== 30'h81) begin errors++; $display("[TB] FAIL ret1: got %h expected %h", pc, 30'h81); end
    go(2'b11, 30'h999, 1'b0);
    checks++; if (pc !== 30'h11) begin errors++; $display("[TB] FAIL ret2: got %h expected %h", pc, 30'h11); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL ret_empty: got %b expected 1", ras_empty); end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("[TB] FAIL ret_no_underflow: got %b expected 0", ras_underflow); end
  endtask

  task automatic test_ras_overflow();
    logic [PC_W-1:0] exp;
    go(2'b10, 30'h1, 1'b0);
    // Calls from 0x1..0x5 push 0x2..0x6; the oldest (0x2) is overwritten.
    for (int i = 2; i <= 5; i++) go(2'b10, PC_W'(i), 1'b1);
    go(2'b10, 30'h40, 1'b1);
    checks++; if (ras_full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full: got %b expected 1", ras_full); end
    for (int i = 0; i < 4; i++) begin
      go(2'b11, 30'h77, 1'b0);
      exp = 30'h6 - PC_W'(i);
      checks++; if (pc !== exp) begin errors++; $display("[TB] FAIL ovf_ret%0d: got %h expected %h", i, pc, exp); end
      checks++; if (ras_underflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_uf%0d: got %b expected 0", i, ras_underflow); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL ovf_empty: got %b expected 1", ras_empty); end
    go(2'b11, 30'h77, 1'b0);
    checks++; if (pc !== 30'h77) begin errors++; $display("[TB] FAIL ovf_fallback: got %h expected %h", pc, 30'h77); end
    checks++; if (ras_underflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_uf_pulse: got %b expected 1", ras_underflow); end
    go(2'b00, '0, 1'b0);
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_uf_clear: got %b expected 0", ras_underflow); end
  endtask

  task automatic test_tail_call();
    go(2'b10, 30'h200, 1'b0);
    go(2'b10, 30'h300, 1'b1);
    go(2'b11, 30'h999, 1'b1);
    checks++; if (pc !== 30'h201) begin errors++; $display("[TB] FAIL tail_pc: got %h expected %h", pc, 30'h201); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("[TB] FAIL tail_count: got %b expected 0", ras_empty); end
    go(2'b11, 30'h999, 1'b0);
    checks++; if (pc !== 30'h301) begin errors++; $display("[TB] FAIL tail_replaced: got %h expected %h", pc, 30'h301); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL tail_empty: got %b expected 1", ras_empty); end
    // Empty-stack tail call: push pc+1 (0x302) and still flag underflow.
    go(2'b11, 30'h400, 1'b1);
    checks++; if (pc !== 30'h400) begin errors++; $display("[TB] FAIL tail_empty_pc: got %h expected %h", pc, 30'h400); end
    checks++; if (ras_underflow !== 1'b1) begin errors++; $display("[TB] FAIL tail_empty_uf: got %b expected 1", ras_underflow); end
    go(2'b11, 30'h999, 1'b0);
    checks++; if (pc !== 30'h302) begin errors++; $display("[TB] FAIL tail_empty_push: got %h expected %h", pc, 30'h302); end
  endtask

  task automatic test_wrap();
    go(2'b10, 30'h3FFFFFFF, 1'b0);
    advance = 1'b0;
    #1;
    checks++; if (incr_pc !== 30'h0) begin errors++; $display("[TB] FAIL wrap_incr: got %h expected %h", incr_pc, 30'h0); end
    go(2'b00, '0, 1'b0);
    checks++; if (pc !== 30'h0) begin errors++; $display("[TB] FAIL wrap_pc: got %h expected %h", pc, 30'h0); end
  endtask

  task automatic test_async_reset();
    go(2'b10, 30'h10, 1'b0);
    go(2'b10, 30'h80, 1'b1);
    go(2'b10, 30'h90, 1'b1);
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("[TB] FAIL areset_pre: got %b expected 0", ras_empty); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 30'h100) begin errors++; $display("[TB] FAIL areset_pc: got %h expected %h", pc, 30'h100); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL areset_empty: got %b expected 1", ras_empty); end
    @(negedge clk);
    rst_n = 1'b1;
    go(2'b11, 30'h123, 1'b0);
    checks++; if (pc !== 30'h123) begin errors++; $display("[TB] FAIL areset_discard: got %h expected %h", pc, 30'h123); end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_branch();
    test_branch_sweep();
    test_stall();
    test_call_return();
    test_ras_overflow();
    test_tail_call();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the RISC core. It generalises the combinational next-address logic in three ways: widths and the reset vector are parametrised, it adds a stall/advance handshake, and it adds a hardware return-address stack (RAS) for call/return.
- It sits between the decode/flag logic and instruction fetch. It owns the architectural PC register and computes the next PC every cycle.

Parameters:
- PC_W, 30, word-address width of the PC.
- JTA_W, 26, jump-target field width; must be less than PC_W.
- RAS_DEPTH, 4, number of return-address stack entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- advance  in  1  when 1 the PC updates this cycle; when 0 the PC and RAS hold (stall).
- zFlag, carryFlag, signFlag, overflowFlag  in  1 each  ALU condition flags.
- brType  in  3  branch condition select.
- pcSel  in  2  next-PC source: 00 = increment, 01 = conditional branch/jump, 10 = register, 11 = return.
- isCall  in  1  push the return address (pc+1) onto the RAS when the PC advances.
- register  in  PC_W  register-indirect target.
- jta  in  JTA_W  jump-target field.
- pc  out  PC_W  current PC (registered).
- incr_pc  out  PC_W  pc+1, combinational, wraps modulo 2^PC_W.
- next_pc  out  PC_W  combinational value the PC will take if advance=1.
- ras_empty  out  1  the RAS holds 0 entries.
- ras_full  out  1  the RAS holds RAS_DEPTH entries.
- ras_underflow  out  1  one-cycle registered pulse; a return was taken with the RAS empty.

Behaviour:
- Reset (async assert, sync deassert):
  - pc = RESET_PC.
  - RAS count = 0 and stack pointer = 0, so ras_empty=1 and ras_full=0.
  - ras_underflow = 0.
- Branch condition brTrue, by brType:
  - 0: always.
  - 1: z.
  - 2: !z.
  - 3: s^v (signed less-than).
  - 4: !(s^v).
  - 5: c (unsigned less-than; carry means borrow).
  - 6: !c.
  - 7: never.
- Branch target = {pc[PC_W-1:JTA_W], jta}.
- next_pc by pcSel:
  - 00: incr_pc.
  - 01: branch target if brTrue, else incr_pc.
  - 10: register.
  - 11: top of RAS if not empty; register if empty (software fallback).
- On a rising edge with advance=1: pc <= next_pc. With advance=0: pc, RAS and count unchanged; ras_underflow <= 0.
- RAS push (advance & isCall & pcSel!=11):
  - Write incr_pc at the pointer, then increment the pointer modulo RAS_DEPTH.
  - count saturates at RAS_DEPTH; when full, the push overwrites the oldest entry (circular).
- RAS pop (advance & pcSel==11):
  - If count>0: decrement the pointer modulo RAS_DEPTH and decrement count.
  - If count==0: no state change, and ras_underflow <= 1 for exactly one cycle.
- Simultaneous pop and isCall (advance & pcSel==11 & isCall), i.e. a tail call through the return path:
  - The popped top entry is replaced in place by incr_pc.
  - count and pointer are unchanged.
  - If the RAS is empty, incr_pc is pushed instead and ras_underflow still pulses.
- Latency:
  - pc reflects a new target one cycle after the request (advance=1).
  - RAS top reflects a push or pop on the next cycle.
  - next_pc and incr_pc are combinational from the current inputs and state.
- Width rules:
  - All PC arithmetic wraps modulo 2^PC_W; pc = all-ones advances to 0.
  - The pointer is log2(RAS_DEPTH) bits; the count is log2(RAS_DEPTH)+1 bits.
- Reset asserted mid-stall or mid-call: everything returns to its reset values immediately; pending pushes are discarded.

Decomposition:
- Shared package holds:
  - brType encodings (BR_ALWAYS … BR_NEVER).
  - pcSel encodings (PCSEL_INCR, PCSEL_BRANCH, PCSEL_REG, PCSEL_RET).
  - Default PC_W and JTA_W.
- One sub-module, branch_cond_eval: a purely combinational flag/brType → brTrue decoder, shared with the core's existing condition logic.
- The RAS stays inline.

Test Plan:
- Reset and increment: release rst_n with RESET_PC=0x100, advance=1, pcSel=00 for 3 cycles → pc sequence 0x100, 0x101, 0x102, 0x103; ras_empty=1.
- Branch conditions: pc=0x3000005, pcSel=01, jta=0x0000040.
  - brType=1 with z=1 → pc=0x3000040.
  - brType=1 with z=0 → pc=0x3000006.
  - Sweep all 8 brType values against all 16 flag combinations and check against the table.
- Stall: pc=0x20 with advance=0 for 4 cycles while pcSel=10 and register=0x55 → pc stays 0x20; next_pc=0x55; on the advance=1 cycle pc=0x55.
- Call/return nesting:
  - Call from 0x10 (isCall=1, pcSel=10, reg=0x80), then call from 0x80 (reg=0x90).
  - Return → pc=0x81. Return → pc=0x11. ras_empty=1.
- RAS overflow, RAS_DEPTH=4: 5 calls from 0x1, 0x2, 0x3, 0x4, 0x5 → ras_full=1; 4 returns yield 0x6, 0x5, 0x4, 0x3; the 5th return with register=0x77 → pc=0x77 and a one-cycle ras_underflow pulse.
- Async reset mid-operation: assert rst_n low between clock edges with 2 RAS entries → pc=RESET_PC and ras_empty=1 immediately, without waiting for a clock edge.
